inst_data_mem_arbiter: RTL and testbench
========================================

// Module: inst_data_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency memory between the CPU instruction-fetch port and data port,
//  allowing a unified code/data memory in the min SOPC. Sits between the core and memory.
//  Fixed data-over-fetch priority, with an anti-starvation guard for fetch.
//  stall_o tells pipeline control that a request is still outstanding.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  MEM_LAT     2   memory access cycles per access, legal 1..15
//  STARVE_MAX  4   fetch losses in a row before fetch is forced to win, legal 1..15
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          reset, asynchronous, active-low
//  if_req_i     in   1          fetch request, held until if_ack_o
//  if_addr_i    in   ADDR_W     fetch address
//  if_rdata_o   out  DATA_W     fetched instruction, valid with if_ack_o
//  if_ack_o     out  1          one-cycle fetch completion pulse
//  dm_req_i     in   1          data request, held until dm_ack_o
//  dm_we_i      in   1          1=write, 0=read
//  dm_be_i      in   DATA_W/8   byte enables
//  dm_addr_i    in   ADDR_W     data address
//  dm_wdata_i   in   DATA_W     write data
//  dm_rdata_o   out  DATA_W     read data, valid with dm_ack_o; 0 for writes
//  dm_ack_o     out  1          one-cycle data completion pulse
//  stall_o      out  1          (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational
//  mem_ce_o     out  1          memory enable
//  mem_we_o     out  1          memory write enable
//  mem_be_o     out  DATA_W/8   memory byte enables
//  mem_addr_o   out  ADDR_W     memory address
//  mem_wdata_o  out  DATA_W     memory write data
//  mem_rdata_i  in   DATA_W     memory read data, valid in last cycle of an access
// BEHAVIOUR
//  - FSM: IDLE -> BUSY -> RESP -> IDLE. State changes and outputs are registered, except stall_o.
//  - IDLE: arbitrate if any request is present, otherwise stay.
//    - Arbitration: dm wins, unless if_req_i=1 and starve_cnt==STARVE_MAX; then if wins.
//    - On grant: latch the winner's addr/we/be/wdata, load cnt=MEM_LAT-1, go BUSY.
//  - Fetch access driving: we=0, be=all ones, wdata=0.
//  - Addresses pass through unchanged. No width conversion.
//  - starve_cnt (4b): +1, saturating at STARVE_MAX, on a dm grant while if_req_i=1; cleared on an if grant.
//  - BUSY:
//    - Drive mem_ce_o=1 and the latched mem_* values, stable for exactly MEM_LAT cycles.
//    - cnt decrements each cycle. When cnt==0, capture mem_rdata_i (0 for writes), go RESP.
//  - RESP:
//    - The granted port's ack=1 for one cycle, rdata valid. mem_ce_o=0.
//    - Then IDLE. Requests seen during RESP are not arbitrated.
//  - Timing: request seen in cycle 0 -> mem_ce_o in cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
//    Peak throughput is one access per MEM_LAT+2 cycles.
//  - Request dropped during BUSY: the access completes and the ack is still issued.
//    Requests are never cancelled.
//  - The port not granted sees ack=0, and its rdata_o holds its last value.
//  - Write with be=0: the access still runs and is acked.
//  - Reset (any time, including mid-BUSY):
//    - State IDLE; cnt, starve_cnt, all mem_* and ack/rdata outputs = 0.
//    - An in-flight access is abandoned with no ack. Normal operation resumes on the first edge after rst=1.
// TESTING
//  1 Reset: rst=0 with if_req_i=1 -> mem_ce_o=0, if_ack_o=0, rdata 0, stall_o=1; rst=1 -> fetch begins next cycle.
//  2 MEM_LAT=2 fetch: if_req_i at cycle 0, addr 0x0000_0100, mem_rdata_i=0x3402_0001
//    -> mem_ce_o=1 with addr 0x100 in cycles 1-2; if_ack_o=1 and if_rdata_o=0x3402_0001 in cycle 3.
//  3 Both requesters at cycle 0, dm read 0x200 -> dm_ack_o in cycle 3; fetch granted in cycle 4, if_ack_o in cycle 7.
//  4 STARVE_MAX=4, dm_req_i and if_req_i held high -> 4 dm acks, then the 5th grant goes to fetch; starve_cnt returns to 0.
//  5 dm write: we=1, be=4'b0011, addr 0x200, wdata 0xDEAD_BEEF
//    -> mem_we_o=1, mem_be_o=0011 and mem_wdata_o=0xDEAD_BEEF for MEM_LAT cycles; dm_ack_o with dm_rdata_o=0.
//  6 rst pulsed low during BUSY -> no ack, all outputs 0; request re-issued after reset completes with normal timing.

Source files
------------

// File: rtl/inst_data_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch and data ports.
// Data wins by default; fetch is forced through after STARVE_MAX consecutive losses.
module inst_data_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_ack_o,
  output logic                stall_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                own_dm_q, own_dm_d;
  logic                ce_d, we_d, if_ack_d, dm_ack_d;
  logic [BE_W-1:0]     be_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d, if_rdata_d, dm_rdata_d, rdata_cap;
  logic                fetch_win;

  assign fetch_win = if_req_i && (!dm_req_i || (starve_q == CNT_W'(STARVE_MAX)));
  assign rdata_cap = mem_we_o ? '0 : mem_rdata_i;
  assign stall_o   = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    own_dm_d   = own_dm_q;
    ce_d       = mem_ce_o;
    we_d       = mem_we_o;
    be_d       = mem_be_o;
    addr_d     = mem_addr_o;
    wdata_d    = mem_wdata_o;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_o;
    dm_rdata_d = dm_rdata_o;
    case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d  = BUSY;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          ce_d     = 1'b1;
          own_dm_d = !fetch_win;
          if (fetch_win) begin
            we_d     = 1'b0;
            be_d     = '1;
            addr_d   = if_addr_i;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            we_d    = dm_we_i;
            be_d    = dm_be_i;
            addr_d  = dm_addr_i;
            wdata_d = dm_wdata_i;
            if (if_req_i && (starve_q != CNT_W'(STARVE_MAX))) starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
          if (own_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = rdata_cap;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rdata_cap;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      own_dm_q    <= 1'b0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      own_dm_q    <= own_dm_d;
      mem_ce_o    <= ce_d;
      mem_we_o    <= we_d;
      mem_be_o    <= be_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
      if_ack_o    <= if_ack_d;
      dm_ack_o    <= dm_ack_d;
      if_rdata_o  <= if_rdata_d;
      dm_rdata_o  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_inst_data_mem_arbiter.sv
// Bench for inst_data_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-timeline model.
module tb_inst_data_mem_arbiter;

  localparam int ML = 2;
  localparam int SM = 4;

  logic        clk;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, stall, mem_ce, mem_we;
  logic [3:0]  mem_be;

  inst_data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(ML), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .stall_o(stall),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Model: one access occupies a timeline starting at grant edge g:
  // ce in cycles g..g+ML-1, ack in g+ML, next grant possible at edge g+ML+2.
  int          g = -1000;
  bit          own_dm;
  int          starve = 0;
  logic        t_we;
  logic [3:0]  t_be;
  logic [31:0] t_addr, t_wdata, cap;
  logic [31:0] exp_if_rdata = '0, exp_dm_rdata = '0;
  bit          exp_if_ack = 0, exp_dm_ack = 0;
  bit          if_drop = 0, dm_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, n, act, exp);
    end
  endtask

  task automatic model_edge();
    int d;
    if (!rst) begin
      g = -1000; starve = 0; cap = '0;
      exp_if_rdata = '0; exp_dm_rdata = '0; exp_if_ack = 0; exp_dm_ack = 0;
      return;
    end
    if ((n - g) >= ML + 2 && (if_req || dm_req)) begin
      g = n;
      own_dm = !(if_req && (!dm_req || starve == SM));
      if (!own_dm) begin
        t_addr = if_addr; t_we = 1'b0; t_be = 4'hF; t_wdata = '0; starve = 0;
      end else begin
        t_addr = dm_addr; t_we = dm_we; t_be = dm_be; t_wdata = dm_wdata;
        if (if_req && starve < SM) starve++;
      end
    end
    d = n - g;
    exp_if_ack = (d == ML) && !own_dm;
    exp_dm_ack = (d == ML) && own_dm;
    if (exp_if_ack) exp_if_rdata = cap;
    if (exp_dm_ack) exp_dm_rdata = cap;
  endtask

  task automatic check_outputs();
    bit ce;
    ce = (n - g) >= 0 && (n - g) < ML;
    chk("mem_ce", 32'(mem_ce), 32'(ce));
    if (ce) begin
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_we", 32'(mem_we), 32'(t_we));
      chk("mem_be", 32'(mem_be), 32'(t_be));
      chk("mem_wdata", mem_wdata, t_wdata);
    end
    chk("if_ack", 32'(if_ack), 32'(exp_if_ack));
    chk("dm_ack", 32'(dm_ack), 32'(exp_dm_ack));
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("dm_rdata", dm_rdata, exp_dm_rdata);
  endtask

  // Inputs for the current cycle are already set by the caller.
  task automatic step();
    bit es;
    #1;
    es = (if_req && !(rst && exp_if_ack)) || (dm_req && !(rst && exp_dm_ack));
    chk("stall", 32'(stall), 32'(es));
    if (rst && (n - g) == ML - 1) cap = t_we ? 32'h0 : mem_rdata;
    @(posedge clk);
    #1;
    n++;
    model_edge();
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = 32'h3402_0001;
    #1;
    // Reset held with a pending fetch
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0100;
    #1;
    chk("rst_stall", 32'(stall), 32'd1);
    step(); step();
    chk("rst_ce", 32'(mem_ce), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    // Single fetch right after reset release
    rst = 1'b1;
    step();
    chk("f_ce1", 32'(mem_ce), 32'd1);
    chk("f_addr1", mem_addr, 32'h100);
    step();
    chk("f_ce2", 32'(mem_ce), 32'd1);
    step();
    chk("f_ack", 32'(if_ack), 32'd1);
    chk("f_rdata", if_rdata, 32'h3402_0001);
    chk("f_ce3", 32'(mem_ce), 32'd0);
    if_req = 1'b0;
    step();
    // Both request together: data first
    if_req = 1'b1; if_addr = 32'h104; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    step(); step(); step();
    chk("both_dm_ack", 32'(dm_ack), 32'd1);
    chk("both_dm_rdata", dm_rdata, 32'h3402_0001);
    chk("both_if_ack3", 32'(if_ack), 32'd0);
    dm_req = 1'b0;
    step(); step();
    chk("both_if_ce5", 32'(mem_ce), 32'd1);
    chk("both_if_addr5", mem_addr, 32'h104);
    step(); step();
    chk("both_if_ack7", 32'(if_ack), 32'd1);
    if_req = 1'b0;
    step();
    // Starvation guard: 4 data wins, then fetch, then data again
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h400; dm_addr = 32'h500;
    for (int i = 1; i <= 23; i++) begin
      step();
      if (i == 3 || i == 7 || i == 11 || i == 15 || i == 23) chk("starve_dm_ack", 32'(dm_ack), 32'd1);
      if (i == 19) chk("starve_if_ack", 32'(if_ack), 32'd1);
      if (i == 19) chk("starve_dm_quiet", 32'(dm_ack), 32'd0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    step();
    // Partial-byte data write
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    step();
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_be", 32'(mem_be), 32'h3);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("wr_ce2", 32'(mem_ce), 32'd1);
    chk("wr_wdata2", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("wr_ack", 32'(dm_ack), 32'd1);
    chk("wr_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    // Reset in the middle of an access
    if_req = 1'b1; if_addr = 32'h300;
    step();
    chk("mid_ce", 32'(mem_ce), 32'd1);
    rst = 1'b0;
    step();
    chk("mid_rst_ce", 32'(mem_ce), 32'd0);
    chk("mid_rst_ack", 32'(if_ack), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("mid_re_ce", 32'(mem_ce), 32'd1);
    chk("mid_re_addr", mem_addr, 32'h300);
    step(); step();
    chk("mid_re_ack", 32'(if_ack), 32'd1);
    if_req = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit if_gr, dm_gr;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0; if_drop = 0; dm_drop = 0;
      end
      if_gr = rst && !own_dm && (n - g) >= 0 && (n - g) < ML;
      dm_gr = rst && own_dm && (n - g) >= 0 && (n - g) < ML;
      if (exp_if_ack || (!if_req && !if_drop)) begin
        if_drop = 0;
        if_req = ($urandom_range(0, 9) < 6);
        if_addr = $urandom;
      end else if (if_req && if_gr && $urandom_range(0, 19) == 0) begin
        if_req = 1'b0; if_drop = 1;
      end
      if (exp_dm_ack || (!dm_req && !dm_drop)) begin
        dm_drop = 0;
        dm_req = ($urandom_range(0, 9) < 6);
        dm_we = 1'($urandom_range(0, 1));
        dm_be = 4'($urandom);
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end else if (dm_req && dm_gr && $urandom_range(0, 19) == 0) begin
        dm_req = 1'b0; dm_drop = 1;
      end
      mem_rdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
